// File: rtl/axi4_burst_slave_mem_if.sv
// AXI4 bus bundle for axi4_burst_slave_mem.
// Contents: all five AXI4 channels (AW, W, B, AR, R) with ID, address, length,
// size, burst, data, strobe, last, response, valid and ready.
// slave modport: used by the memory endpoint.
// master modport: used by whatever issues bursts into it.
interface axi4_burst_slave_mem_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    input  rready,
    output awready, wready, bid, bresp, bvalid,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    output rready,
    input  awready, wready, bid, bresp, bvalid,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_burst_slave_mem.sv
// AXI4 slave with an internal word-addressed memory.
// It accepts one write burst and one read burst at a time. Each direction has
// its own FSM, and the two run concurrently. It supports FIXED, INCR and WRAP
// bursts and narrow sizes, and returns OKAY, SLVERR or DECERR.
// Ports:
//   aclk   - clock; all logic is on the rising edge
//   areset - synchronous reset, active-high
//   s_axi  - AXI4 slave modport, carrying all five channels
//
// state  | meaning
// W_IDLE | awready=1, waiting for a write command
// W_DATA | wready=1, accepting beats until beat len
// W_RESP | bvalid=1, holding the response until bready
// R_IDLE | arready=1, waiting for a read command
// R_DATA | rvalid=1, presenting beats until the beat with rlast is taken
module axi4_burst_slave_mem #(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 1024
) (
  input logic                   aclk,
  input logic                   areset,
  axi4_burst_slave_mem_if.slave s_axi
);
  localparam int NB     = DATA_W / 8;
  localparam int SZ_MAX = $clog2(NB);
  localparam int MIDX_W = $clog2(MEM_WORDS);
  localparam int IDX_W  = ADDR_W - SZ_MAX;
  localparam logic [IDX_W-1:0]  MEM_LIM = IDX_W'(MEM_WORDS);
  localparam logic [2:0]        SZ_MAX3 = 3'(SZ_MAX);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_W-1:0] incr, nxt, wmask, res;
    incr  = ONE << size;
    nxt   = (a & ~(incr - ONE)) + incr;
    wmask = ((ADDR_W'(len) + ONE) << size) - ONE;
    case (burst)
      2'b00:   res = a;
      2'b10:   res = (a & ~wmask) | (nxt & wmask);
      default: res = nxt;  // INCR, and reserved bursts advance like INCR
    endcase
    return res;
  endfunction

  function automatic logic cmd_err(input logic [7:0] len, input logic [2:0] size,
      input logic [1:0] burst);
    logic wrap_bad;
    wrap_bad = (burst == 2'b10) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (burst == 2'b11) || (size > SZ_MAX3) || wrap_bad;
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:SZ_MAX] < MEM_LIM;
  endfunction

  function automatic logic [MIDX_W-1:0] widx(input logic [ADDR_W-1:0] a);
    return a[SZ_MAX +: MIDX_W];
  endfunction

  // ---------------- write side ----------------
  w_state_t          w_state, w_next;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len, w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic              w_slverr, w_decerr;
  logic              aw_hs, w_hs, w_last_beat, w_slv_now, w_dec_now, w_en;

  assign s_axi.awready = (w_state == W_IDLE) && !areset;
  assign s_axi.wready  = (w_state == W_DATA) && !areset;
  assign s_axi.bvalid  = (w_state == W_RESP) && !areset;
  assign s_axi.bid     = s_axi.bvalid ? w_id : '0;
  assign s_axi.bresp   = s_axi.bvalid ? {w_decerr | w_slverr, w_decerr} : 2'b00;

  assign aw_hs       = s_axi.awvalid && s_axi.awready;
  assign w_hs        = s_axi.wvalid && s_axi.wready;
  assign w_last_beat = (w_cnt == w_len);
  // The error flags are sticky. Once either is set, no later beat of the
  // burst touches memory.
  assign w_slv_now = w_slverr || cmd_err(w_len, w_size, w_burst) ||
                     (s_axi.wlast != w_last_beat);
  assign w_dec_now = w_decerr || !in_range(w_addr);
  assign w_en      = w_hs && !w_slv_now && !w_dec_now;

  always_ff @(posedge aclk) begin
    if (areset) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (s_axi.awvalid) w_next = W_DATA;
      W_DATA:  if (s_axi.wvalid && w_last_beat) w_next = W_RESP;
      W_RESP:  if (s_axi.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_id     <= '0;
      w_addr   <= '0;
      w_len    <= '0;
      w_size   <= '0;
      w_burst  <= '0;
      w_cnt    <= '0;
      w_slverr <= 1'b0;
      w_decerr <= 1'b0;
    end else begin
      if (aw_hs) begin
        w_id     <= s_axi.awid;
        w_addr   <= s_axi.awaddr;
        w_len    <= s_axi.awlen;
        w_size   <= s_axi.awsize;
        w_burst  <= s_axi.awburst;
        w_cnt    <= '0;
        w_slverr <= 1'b0;
        w_decerr <= 1'b0;
      end
      if (w_hs) begin
        w_addr   <= next_addr(w_addr, w_len, w_size, w_burst);
        w_cnt    <= w_cnt + 8'd1;
        w_slverr <= w_slv_now;
        w_decerr <= w_dec_now;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (w_en)
      for (int b = 0; b < NB; b++)
        if (s_axi.wstrb[b]) mem[widx(w_addr)][8*b +: 8] <= s_axi.wdata[8*b +: 8];
  end

  // ---------------- read side ----------------
  r_state_t          r_state, r_next;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr, r_ld_addr;
  logic [7:0]        r_len, r_cnt;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic [DATA_W-1:0] r_data, r_ld_word;
  logic              ar_hs, r_hs, r_last_beat, r_ld_err, r_dec, r_slv;

  assign s_axi.arready = (r_state == R_IDLE) && !areset;
  assign s_axi.rvalid  = (r_state == R_DATA) && !areset;
  assign ar_hs         = s_axi.arvalid && s_axi.arready;
  assign r_hs          = s_axi.rvalid && s_axi.rready;
  assign r_last_beat   = (r_cnt == r_len);
  assign r_dec         = !in_range(r_addr);
  assign r_slv         = cmd_err(r_len, r_size, r_burst);
  assign s_axi.rid     = s_axi.rvalid ? r_id : '0;
  assign s_axi.rdata   = s_axi.rvalid ? r_data : '0;
  assign s_axi.rresp   = s_axi.rvalid ? {r_dec | r_slv, r_dec} : 2'b00;
  assign s_axi.rlast   = s_axi.rvalid && r_last_beat;

  always_ff @(posedge aclk) begin
    if (areset) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (s_axi.arvalid) r_next = R_DATA;
      R_DATA:  if (s_axi.rready && r_last_beat) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // The beat data is captured into r_data when the beat is loaded, so the
  // payload stays stable during a stall. A write landing on the same edge is
  // merged in here, which makes it visible to the next beat.
  always_comb begin
    r_ld_addr = ar_hs ? s_axi.araddr : next_addr(r_addr, r_len, r_size, r_burst);
    r_ld_err  = ar_hs ? cmd_err(s_axi.arlen, s_axi.arsize, s_axi.arburst) : r_slv;
    r_ld_err  = r_ld_err || !in_range(r_ld_addr);
    r_ld_word = mem[widx(r_ld_addr)];
    if (w_en && (widx(w_addr) == widx(r_ld_addr)))
      for (int b = 0; b < NB; b++)
        if (s_axi.wstrb[b]) r_ld_word[8*b +: 8] = s_axi.wdata[8*b +: 8];
    if (r_ld_err) r_ld_word = '0;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      if (ar_hs) begin
        r_id    <= s_axi.arid;
        r_addr  <= s_axi.araddr;
        r_len   <= s_axi.arlen;
        r_size  <= s_axi.arsize;
        r_burst <= s_axi.arburst;
        r_cnt   <= '0;
      end
      if (r_hs) begin
        r_addr <= r_ld_addr;
        r_cnt  <= r_cnt + 8'd1;
      end
      if (ar_hs || r_hs) r_data <= r_ld_word;
    end
  end
endmodule

// File: tb/tb_axi4_burst_slave_mem.sv
// Testbench for axi4_burst_slave_mem.
// Stimulus comes from directed vectors. Each expected B or R response is
// pushed onto a queue. A separate monitor pops an entry and compares it at
// every B and R handshake, and it also checks that the R payload stays stable
// while the slave is stalled.
module tb_axi4_burst_slave_mem;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  axi4_burst_slave_mem_if #(.ID_W(4), .ADDR_W(16), .DATA_W(32)) bus ();

  axi4_burst_slave_mem #(.ID_W(4), .ADDR_W(16), .DATA_W(32), .MEM_WORDS(1024)) dut (
    .aclk(aclk), .areset(areset), .s_axi(bus)
  );

  typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;
  b_exp_t exp_b[$];
  r_exp_t exp_r[$];
  int tests = 0;
  int fails = 0;
  bit r_rand = 1'b0;
  bit w_stall = 1'b0;
  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string what);
    tests++;
    fails++;
    $display("FAIL %s_timeout: got no handshake want handshake", what);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic er(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp,
                    input logic last);
    exp_r.push_back('{id: id, data: d, resp: resp, last: last});
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [15:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bt);
    int n = 0;
    bus.awid = id; bus.awaddr = a; bus.awlen = len; bus.awsize = sz; bus.awburst = bt;
    bus.awvalid = 1'b1;
    while (!bus.awready && n < 2000) begin tick(); n++; end
    if (n >= 2000) tmo("aw");
    tick();
    bus.awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [15:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bt);
    int n = 0;
    bus.arid = id; bus.araddr = a; bus.arlen = len; bus.arsize = sz; bus.arburst = bt;
    bus.arvalid = 1'b1;
    while (!bus.arready && n < 2000) begin tick(); n++; end
    if (n >= 2000) tmo("ar");
    tick();
    bus.arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic last);
    int n = 0;
    if (w_stall) repeat ($urandom_range(0, 2)) tick();
    bus.wdata = d; bus.wstrb = s; bus.wlast = last; bus.wvalid = 1'b1;
    while (!bus.wready && n < 2000) begin tick(); n++; end
    if (n >= 2000) tmo("w");
    tick();
    bus.wvalid = 1'b0;
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [15:0] a, input logic [7:0] len,
                             input logic [1:0] bt, input int early, input logic [1:0] eresp);
    exp_b.push_back('{id: id, resp: eresp});
    send_aw(id, a, len, 3'd2, bt);
    for (int i = 0; i <= int'(len); i++)
      send_w(wdat[i], wstb[i], (i == int'(len)) || (i == early));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 3000) begin tick(); n++; end
    if (n >= 3000) tmo("idle");
    tick();
  endtask

  task automatic wr1(input logic [15:0] a, input logic [31:0] d);
    wdat[0] = d; wstb[0] = 4'hF;
    write_burst(4'h0, a, 8'd0, 2'b01, -1, 2'b00);
    wait_idle();
  endtask

  initial begin
    bus.rready = 1'b1;
    forever begin
      tick();
      bus.rready = r_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : monitor
    logic [38:0] held;
    bit stalled;
    b_exp_t be;
    r_exp_t re;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge aclk);
      if (areset) stalled = 1'b0;
      else begin
        if (bus.bvalid && bus.bready) begin
          if (exp_b.size() == 0) begin
            tests++; fails++;
            $display("FAIL b_unexpected: got bresp %b want no response", bus.bresp);
          end else begin
            be = exp_b.pop_front();
            chk("bid", 64'(bus.bid), 64'(be.id));
            chk("bresp", 64'(bus.bresp), 64'(be.resp));
          end
        end
        if (stalled) begin
          chk("r_hold_valid", 64'(bus.rvalid), 64'(1));
          chk("r_hold_payload", 64'({bus.rid, bus.rdata, bus.rresp, bus.rlast}), 64'(held));
        end
        stalled = 1'b0;
        if (bus.rvalid && !bus.rready) begin
          stalled = 1'b1;
          held = {bus.rid, bus.rdata, bus.rresp, bus.rlast};
        end
        if (bus.rvalid && bus.rready) begin
          if (exp_r.size() == 0) begin
            tests++; fails++;
            $display("FAIL r_unexpected: got rdata %h want no beat", bus.rdata);
          end else begin
            re = exp_r.pop_front();
            chk("rid", 64'(bus.rid), 64'(re.id));
            chk("rdata", 64'(bus.rdata), 64'(re.data));
            chk("rresp", 64'(bus.rresp), 64'(re.resp));
            chk("rlast", 64'(bus.rlast), 64'(re.last));
          end
        end
      end
    end
  end

  initial begin
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0; bus.bready = 1'b1;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    areset = 1'b1;
    repeat (3) tick();
    chk("rst_awready", 64'(bus.awready), 64'(0));
    chk("rst_wready", 64'(bus.wready), 64'(0));
    chk("rst_bvalid", 64'(bus.bvalid), 64'(0));
    chk("rst_arready", 64'(bus.arready), 64'(0));
    chk("rst_rvalid", 64'(bus.rvalid), 64'(0));
    areset = 1'b0;
    tick();
    chk("idle_awready", 64'(bus.awready), 64'(1));
    chk("idle_arready", 64'(bus.arready), 64'(1));

    // single write then read
    wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
    write_burst(4'h3, 16'h0010, 8'd0, 2'b01, -1, 2'b00);
    wait_idle();
    er(4'h5, 32'hDEADBEEF, 2'b00, 1'b1);
    send_ar(4'h5, 16'h0010, 8'd0, 3'd2, 2'b01);
    wait_idle();

    // INCR burst with wvalid gaps and rready stalls
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); wstb[i] = 4'hF; end
    w_stall = 1'b1; r_rand = 1'b1;
    write_burst(4'h1, 16'h0100, 8'd3, 2'b01, -1, 2'b00);
    wait_idle();
    for (int i = 0; i < 4; i++) er(4'h2, 32'(i + 1), 2'b00, i == 3);
    send_ar(4'h2, 16'h0100, 8'd3, 3'd2, 2'b01);
    wait_idle();
    w_stall = 1'b0; r_rand = 1'b0;

    // WRAP write from 0x28 lands at 0x28,0x2C,0x20,0x24
    write_burst(4'h6, 16'h0028, 8'd3, 2'b10, -1, 2'b00);
    wait_idle();
    er(4'h7, 32'd3, 2'b00, 1'b0); er(4'h7, 32'd4, 2'b00, 1'b0);
    er(4'h7, 32'd1, 2'b00, 1'b0); er(4'h7, 32'd2, 2'b00, 1'b1);
    send_ar(4'h7, 16'h0020, 8'd3, 3'd2, 2'b01);
    wait_idle();
    for (int i = 0; i < 4; i++) er(4'h8, 32'(i + 1), 2'b00, i == 3);
    send_ar(4'h8, 16'h0028, 8'd3, 3'd2, 2'b10);
    wait_idle();

    // FIXED burst with byte strobes
    wr1(16'h0040, 32'h0);
    wdat[0] = 32'h000000AA; wstb[0] = 4'h1;
    wdat[1] = 32'h00BB0000; wstb[1] = 4'h4;
    write_burst(4'h7, 16'h0040, 8'd1, 2'b00, -1, 2'b00);
    wait_idle();
    er(4'h1, 32'h00BB00AA, 2'b00, 1'b1);
    send_ar(4'h1, 16'h0040, 8'd0, 3'd2, 2'b01);
    wait_idle();

    // DECERR write leaves memory alone (word 0 shares low index bits)
    wr1(16'h0000, 32'h11111111);
    wdat[0] = 32'h12345678; wstb[0] = 4'hF;
    write_burst(4'h2, 16'h1000, 8'd0, 2'b01, -1, 2'b11);
    wait_idle();
    er(4'h0, 32'h11111111, 2'b00, 1'b1);
    send_ar(4'h0, 16'h0000, 8'd0, 3'd2, 2'b01);
    wait_idle();

    // read crossing the end of memory: OKAY beat, then DECERR beat with data 0
    wr1(16'h0FFC, 32'h0FFC0FFC);
    er(4'h4, 32'h0FFC0FFC, 2'b00, 1'b0);
    er(4'h4, 32'h0, 2'b11, 1'b1);
    send_ar(4'h4, 16'h0FFC, 8'd1, 3'd2, 2'b01);
    wait_idle();

    // reserved burst gives SLVERR and no write
    wr1(16'h0080, 32'h80808080);
    wdat[0] = 32'hDEADDEAD; wstb[0] = 4'hF;
    write_burst(4'h5, 16'h0080, 8'd0, 2'b11, -1, 2'b10);
    wait_idle();
    er(4'h3, 32'h80808080, 2'b00, 1'b1);
    send_ar(4'h3, 16'h0080, 8'd0, 3'd2, 2'b01);
    wait_idle();

    // oversized read and illegal WRAP length read
    er(4'h3, 32'h0, 2'b10, 1'b1);
    send_ar(4'h3, 16'h0010, 8'd0, 3'd3, 2'b01);
    wait_idle();
    er(4'h9, 32'h0, 2'b10, 1'b0); er(4'h9, 32'h0, 2'b10, 1'b0); er(4'h9, 32'h0, 2'b10, 1'b1);
    send_ar(4'h9, 16'h0010, 8'd2, 3'd2, 2'b10);
    wait_idle();

    // early wlast on beat 1: only beat 0 written
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hA0 + 32'(i); wstb[i] = 4'hF; end
    write_burst(4'h9, 16'h0300, 8'd3, 2'b01, -1, 2'b00);
    wait_idle();
    for (int i = 0; i < 4; i++) wdat[i] = 32'hB0 + 32'(i);
    write_burst(4'h9, 16'h0300, 8'd3, 2'b01, 1, 2'b10);
    wait_idle();
    er(4'hA, 32'hB0, 2'b00, 1'b0); er(4'hA, 32'hA1, 2'b00, 1'b0);
    er(4'hA, 32'hA2, 2'b00, 1'b0); er(4'hA, 32'hA3, 2'b00, 1'b1);
    send_ar(4'hA, 16'h0300, 8'd3, 3'd2, 2'b01);
    wait_idle();

    // reset during beat 2 of a len-7 write
    for (int i = 0; i < 8; i++) begin wdat[i] = 32'hCAFE0000 + 32'(i); wstb[i] = 4'hF; end
    write_burst(4'h1, 16'h0200, 8'd7, 2'b01, -1, 2'b00);
    wait_idle();
    send_aw(4'h1, 16'h0200, 8'd7, 3'd2, 2'b01);
    send_w(32'h5EED0000, 4'hF, 1'b0);
    send_w(32'h5EED0001, 4'hF, 1'b0);
    bus.wdata = 32'h5EED0002; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
    areset = 1'b1;
    tick();
    chk("mid_rst_wready", 64'(bus.wready), 64'(0));
    chk("mid_rst_bvalid", 64'(bus.bvalid), 64'(0));
    areset = 1'b0;
    bus.wvalid = 1'b0;
    tick();
    chk("post_rst_awready", 64'(bus.awready), 64'(1));
    chk("post_rst_wready", 64'(bus.wready), 64'(0));
    er(4'hB, 32'h5EED0000, 2'b00, 1'b0);
    er(4'hB, 32'h5EED0001, 2'b00, 1'b0);
    for (int i = 2; i < 8; i++) er(4'hB, 32'hCAFE0000 + 32'(i), 2'b00, i == 7);
    send_ar(4'hB, 16'h0200, 8'd7, 3'd2, 2'b01);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
